// File: rtl/mem_wait_responder_pkg.sv
// Shared types and widths for the main-memory wait-state responder.
`default_nettype none

package mem_pkg;

    localparam int WORD_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_responder_if.sv
// Cache miss/write-back port: request handshake from the cache, completion back to it.
`default_nettype none

interface mem_wait_responder_if;
    import mem_pkg::*;

    logic              MStrobe;
    logic              MRW;
    logic [31:0]       MAddress;
    logic [WORD_W-1:0] MDataOut;
    logic [WORD_W-1:0] MDataIn;
    logic              MReady;
    logic              MBusy;

    modport master (
        output MStrobe, MRW, MAddress, MDataOut,
        input  MDataIn, MReady, MBusy
    );

    modport slave (
        input  MStrobe, MRW, MAddress, MDataOut,
        output MDataIn, MReady, MBusy
    );

endinterface

`default_nettype wire

// File: rtl/mem_wait_responder_array.sv
// Single-port word storage: synchronous write, registered read output.
`default_nettype none

module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Storage deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_wait_responder.sv
// Handshaked main-memory target: answers MStrobe after WAIT_CYCLES wait states with a one-cycle MReady.
`default_nettype none

module mem_wait_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_wait_responder_if.slave  bus
);

    localparam int              IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_W-1:0] CNT_LOAD =
        ZERO_WAIT ? '0 : WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t        state;
    mem_state_t        next_state;
    logic [WAIT_W-1:0] cnt;
    logic              lat_rw;
    logic [IDX_W-1:0]  lat_idx;
    logic [WORD_W-1:0] lat_data;
    logic              ready;
    logic              busy;

    logic              accept;
    logic              enter_done;
    logic              cur_rw;
    logic [IDX_W-1:0]  cur_idx;
    logic [WORD_W-1:0] cur_data;
    logic              unused_addr_bits;

    assign accept  = (state == IDLE) && bus.MStrobe;
    assign unused_addr_bits = ^{bus.MAddress[31:IDX_W+2], bus.MAddress[1:0]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.MStrobe) next_state = ZERO_WAIT ? DONE : WAIT;
            WAIT:    if (cnt == '0)   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_done = (next_state == DONE);

    // With zero wait states the commit happens on the accepting edge itself,
    // before the latches hold anything, so the live inputs are used then.
    assign cur_rw   = (state == IDLE) ? bus.MRW                     : lat_rw;
    assign cur_idx  = (state == IDLE) ? bus.MAddress[IDX_W+1:2]     : lat_idx;
    assign cur_data = (state == IDLE) ? bus.MDataOut                : lat_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_rw   <= 1'b0;
            lat_idx  <= '0;
            lat_data <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= next_state;
            ready <= enter_done;
            busy  <= (next_state != IDLE);
            if (accept) begin
                cnt      <= CNT_LOAD;
                lat_rw   <= bus.MRW;
                lat_idx  <= bus.MAddress[IDX_W+1:2];
                lat_data <= bus.MDataOut;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (enter_done && cur_rw),
        .re    (enter_done && !cur_rw),
        .addr  (cur_idx),
        .wdata (cur_data),
        .rdata (bus.MDataIn)
    );

    assign bus.MReady = ready;
    assign bus.MBusy  = busy;

endmodule

`default_nettype wire
